// File: rtl/clk_enable_gen.sv
// ---------------------------------------------------------------------------
// clk_enable_gen
//
// Purpose:
//   Generates NCH independent clock-enable channels (index 0..2 = cpu, ppu,
//   vga by default) from a single system clock, together with a
//   synchronously released system reset for downstream logic.
//   Each channel divides the clock by a latched divisor and produces a
//   one-cycle enable pulse (ce) plus a registered clock-like level (lvl).
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   n_reset    in   asynchronous active-low reset
//   run        in   1 = channel counters advance, 0 = hold (ce suppressed)
//   sync_req   in   one-cycle request to phase-align all channels to cnt=0
//   div        in   per-channel divisor, channel i at [i*CW +: CW], 0 == 1
//   ce         out  per-channel one-cycle enable pulse (registered)
//   lvl        out  per-channel registered clock level, high for the upper
//                   part of the count range (cnt >= D/2)
//   reset      out  active-high system reset, released synchronously
//   rst_state  out  debug view of the reset sequencer state
//                   (0 = ASSERT, 1 = HOLD, 2 = RELEASE)
// ---------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int NCH      = 3,
    parameter int CW       = 8,
    parameter int RST_HOLD = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              run,
    input  logic              sync_req,
    input  logic [NCH*CW-1:0] div,
    output logic [NCH-1:0]    ce,
    output logic [NCH-1:0]    lvl,
    output logic              reset,
    output logic [1:0]        rst_state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } rst_state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD);

    rst_state_t  state;
    logic [15:0] hold_cnt;

    assign rst_state = state;

    // -----------------------------------------------------------------------
    // Reset sequencer.
    // The first rising edge with n_reset high moves ASSERT -> HOLD and counts
    // as edge 1. After RST_HOLD such edges the counter equals RST_HOLD, and
    // the following edge drops reset. Any n_reset low returns to ASSERT and
    // clears the count, so a glitch mid-hold restarts the whole sequence.
    // Deassertion of n_reset never changes an output by itself; only a clock
    // edge can move the sequencer.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
            reset    <= 1'b1;
        end else begin
            case (state)
                ST_ASSERT: begin
                    state    <= ST_HOLD;
                    hold_cnt <= 16'd1;
                    reset    <= 1'b1;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_RELEASE;
                        reset <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    reset <= 1'b0;
                end
                default: begin
                    state    <= ST_ASSERT;
                    hold_cnt <= '0;
                    reset    <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Enable channels.
    // Channel logic looks at the registered reset, so on the edge where reset
    // falls the counters are still held at 0; counting starts on the next
    // edge with every channel at cnt=0, i.e. phase aligned.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] d_q;
        logic [CW-1:0] div_in;
        logic [CW-1:0] div_eff;
        logic [CW-1:0] cnt_nxt;
        logic [CW-1:0] d_nxt;
        logic          term;
        logic          ce_q;
        logic          lvl_q;

        always_comb begin
            div_in  = div[g*CW +: CW];
            // A programmed divisor of 0 behaves as divide-by-1.
            div_eff = (div_in == '0) ? CW'(1) : div_in;
            term    = (cnt_q == (d_q - CW'(1)));
            // The divisor is only picked up at the wrap, so a change in the
            // middle of a period affects the next period, never the current.
            if (term) begin
                cnt_nxt = '0;
                d_nxt   = div_eff;
            end else begin
                cnt_nxt = cnt_q + CW'(1);
                d_nxt   = d_q;
            end
        end

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                cnt_q <= '0;
                d_q   <= CW'(1);
                ce_q  <= 1'b0;
                lvl_q <= 1'b0;
            end else if (reset) begin
                // Track div continuously so the first period after release
                // uses the value present at release.
                cnt_q <= '0;
                d_q   <= div_eff;
                ce_q  <= 1'b0;
                lvl_q <= 1'b0;
            end else if (sync_req) begin
                // Sync overrides run and any terminal count in this cycle.
                cnt_q <= '0;
                d_q   <= div_eff;
                ce_q  <= 1'b0;
                lvl_q <= ((div_eff >> 1) == '0);
            end else if (run) begin
                cnt_q <= cnt_nxt;
                d_q   <= d_nxt;
                ce_q  <= term;
                lvl_q <= (cnt_nxt >= (d_nxt >> 1));
            end else begin
                // Paused: counter and level hold, no enable pulses.
                ce_q <= 1'b0;
            end
        end

        assign ce[g]  = ce_q;
        assign lvl[g] = lvl_q;
    end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter NCH, default 3, number of independent clock-enable channels (cpu, ppu, vga order for indices 0..2).
REQ-002 Parameter CW, default 8, width of each channel's divide counter and divisor.
REQ-003 Parameter RST_HOLD, default 16, cycles `reset` stays high after `n_reset` deasserts; legal range 1..2^16-1.
REQ-004 Port clk, input, 1: single system clock; all state on rising edge.
REQ-005 Port n_reset, input, 1: asynchronous, active-low reset.
REQ-006 Port run, input, 1: 1 = counters advance; 0 = counters hold, enables suppressed.
REQ-007 Port sync_req, input, 1: one-cycle request to phase-align all channels.
REQ-008 Port div, input, NCH*CW: per-channel divisor, channel i at bits [i*CW +: CW].
REQ-009 Port ce, output, NCH: per-channel one-cycle enable pulse.
REQ-010 Port lvl, output, NCH: per-channel registered 50%-style clock level (M2-style phase).
REQ-011 Port reset, output, 1: active-high synchronous-release system reset for downstream logic.

Function
REQ-012 Effective divisor D_i SHALL be latched div_i, with latched value 0 treated as 1.
REQ-013 Channel counter cnt_i SHALL count 0..D_i-1 then wrap to 0, advancing once per cycle when run=1 and reset=0.
REQ-014 ce[i] SHALL be registered, high exactly in the cycle following the cycle in which cnt_i == D_i-1 and the counter advanced; period D_i cycles, width 1 cycle.
REQ-015 D_i=1: ce[i] SHALL be high every cycle while advancing.
REQ-016 div_i SHALL be sampled into the latch only when cnt_i wraps (or at sync/reset release); mid-period div changes SHALL NOT shorten or stretch the current period.
REQ-017 lvl[i] SHALL be registered: 1 when next cnt_i >= (D_i >> 1), else 0; for D_i=1 lvl[i] constant 1; for odd D_i low phase is floor(D_i/2) cycles.
REQ-018 run=0: cnt_i and lvl[i] SHALL hold, ce SHALL be 0 the following cycle; on run returning to 1 counting resumes from held value.
REQ-019 sync_req=1 (with reset=0): all cnt_i SHALL load 0, all div latches reload, ce SHALL be 0 next cycle, regardless of run.
REQ-020 sync_req and a terminal count in the same cycle: sync wins, no ce pulse.
REQ-021 Reset sequencer states: ASSERT (reset=1, hold counter cleared) -> HOLD (n_reset high, counting RST_HOLD cycles) -> RELEASE (reset=0).
REQ-022 reset SHALL fall on the edge after RST_HOLD consecutive rising edges with n_reset high.
REQ-023 While reset=1: cnt_i SHALL hold 0, ce=0, lvl=0, div latches continuously reload from div.
REQ-024 Channel counting SHALL begin the cycle after reset falls, all channels starting at cnt=0 (phase-aligned).

Reset
REQ-025 n_reset low SHALL asynchronously force reset=1, ce=0, lvl=0, all cnt_i=0, hold counter=0, state ASSERT.
REQ-026 n_reset low mid-HOLD or mid-operation SHALL restart the full RST_HOLD sequence on deassertion.
REQ-027 No output SHALL glitch on n_reset deassertion; release is purely synchronous.

Verification
REQ-028 n_reset low 3 cycles then high, RST_HOLD=16 -> reset=1 for exactly 16 edges after release, ce all 0 throughout, first count at cnt=0 next cycle.
REQ-029 div={12,4,2}, run=1 -> ce[0] every 12, ce[1] every 4, ce[2] every 2 cycles; lvl[1] pattern 0,0,1,1; all ce coincide every 12 cycles.
REQ-030 div_0 changed 12->6 at cnt_0=3 -> current period stays 12, following periods 6; div_0=0 -> ce[0] every cycle, lvl[0]=1.
REQ-031 run low for 5 cycles at cnt_1=2 -> no ce during hold, next ce[1] 2 cycles after run returns; sync_req at cnt_0=11 -> no ce[0] that cycle, all channels restart at 0.
REQ-032 n_reset pulsed low during HOLD at count 9 and during normal run -> outputs cleared immediately, full 16-cycle hold repeated.
REQ-033 Odd D=5 -> lvl low 2 cycles, high 3 cycles, ce period 5.
